// File: rtl/imem_loader_if.sv
// imem_loader_if
// Load-side handshake bundle for imem_loader: the load request with its word
// count, and the little-endian byte stream with its valid/ready handshake.
//   load_start  : one-cycle request to begin a load (master -> slave)
//   load_len    : program length in words, AW+1 bits (master -> slave)
//   byte_valid  : byte_data carries a stream byte (master -> slave)
//   byte_data   : stream byte, little-endian within each word (master -> slave)
//   byte_ready  : loader accepts a byte this cycle (slave -> master)
// The master modport is the external load source; the slave is the loader.
interface imem_loader_if #(
   parameter int AW = 6
);
   logic          load_start;
   logic [AW:0]   load_len;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;

   modport master (
      output load_start,
      output load_len,
      output byte_valid,
      output byte_data,
      input  byte_ready
   );

   modport slave (
      input  load_start,
      input  load_len,
      input  byte_valid,
      input  byte_data,
      output byte_ready
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time program loader and fetch gate for the instruction memory of the
// single-cycle core. Bytes arrive little-endian over a valid/ready stream,
// are packed into 32-bit words and written sequentially through the memory
// write port. Until the whole program is in place the core is held:
// core_run stays low and every fetch sees a NOP.
//
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   ld           : imem_loader_if.slave (load_start, load_len, byte stream)
//   pc_addr      : core fetch byte address
//   mem_raddr    : memory read word address, pc_addr[AW+1:2]
//   mem_rdata    : memory read data (combinational read)
//   fetch_instr  : instruction handed to the core (NOP while held)
//   mem_we/mem_waddr/mem_wdata : memory write port
//   core_run     : core released
//   busy         : load in progress (LOAD, WRITE, CHECK)
//   err          : last load request or load failed
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// 32-bit word equal to the modulo-2^32 sum of the program words before the
// core is released.
module imem_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic              clk,
   input  logic              reset,
   imem_loader_if.slave      ld,
   input  logic [31:0]       pc_addr,
   output logic [AW-1:0]     mem_raddr,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       fetch_instr,
   output logic              mem_we,
   output logic [AW-1:0]     mem_waddr,
   output logic [31:0]       mem_wdata,
   output logic              core_run,
   output logic              busy,
   output logic              err
);

   localparam logic [31:0] NOP     = 32'h00000013;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      CHECK,
      RUN,
      ERR
   } state_t;

   state_t        state;
   state_t        next_state;

   logic [AW:0]   word_cnt;
   logic [AW:0]   len_q;
   logic [1:0]    byte_cnt;
   logic [31:0]   word_buf;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]   sum_q;
`endif

   logic          len_ok;
   logic          start_accept;
   logic          byte_ready_c;
   logic          byte_take;
   logic          last_byte;
   logic          last_word;
   logic [31:0]   word_next;

   // Only pc_addr[AW+1:2] selects a word; the rest of the address is unused.
   logic          unused_pc_bits;
   assign unused_pc_bits = ^{pc_addr[31:AW+2], pc_addr[1:0]};

   // A request is legal only if the program fits the memory and is non-empty,
   // which is also what keeps the word index from ever wrapping.
   assign len_ok    = (ld.load_len != '0) && (ld.load_len <= DEPTH_W);
   assign byte_take = ld.byte_valid && byte_ready_c;
   assign last_byte = byte_take && (byte_cnt == 2'd3);
   assign last_word = (word_cnt + (AW+1)'(1)) == len_q;
   // The buffer shifts right, so the fourth byte lands in [31:24] and the
   // first byte ends up in [7:0].
   assign word_next = {ld.byte_data, word_buf[31:8]};

   // State register for the load sequencer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and per-state control. IDLE, RUN and ERR all treat
   // load_start identically; the busy states ignore it.
   always_comb begin
      next_state   = state;
      start_accept = 1'b0;
      byte_ready_c = 1'b0;
      case (state)
         IDLE, RUN, ERR: begin
            if (ld.load_start) begin
               if (len_ok) begin
                  next_state   = LOAD;
                  start_accept = 1'b1;
               end else begin
                  next_state = ERR;
               end
            end
         end
         LOAD: begin
            byte_ready_c = 1'b1;
            if (last_byte) begin
               next_state = WRITE;
            end
         end
         WRITE: begin
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               next_state = CHECK;
`else
               next_state = RUN;
`endif
            end else begin
               next_state = LOAD;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            byte_ready_c = 1'b1;
            if (last_byte) begin
               next_state = (word_next == sum_q) ? RUN : ERR;
            end
         end
`endif
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Word assembly, word index, latched length and (optionally) the running
   // sum. Counters restart on every accepted request so a reset or aborted
   // load never leaks a partial word into the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_cnt <= '0;
         len_q    <= '0;
         byte_cnt <= '0;
         word_buf <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q    <= '0;
`endif
      end else begin
         if (start_accept) begin
            word_cnt <= '0;
            byte_cnt <= '0;
            len_q    <= ld.load_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
         end
         if (byte_take) begin
            word_buf <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (state == WRITE) begin
            word_cnt <= word_cnt + (AW+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= sum_q + word_buf;
`endif
         end
      end
   end

   // Outputs decoded from the state; write address/data are forced to zero
   // outside WRITE so the port is quiet whenever mem_we is low.
   assign ld.byte_ready = byte_ready_c;
   assign mem_we        = (state == WRITE);
   assign mem_waddr     = (state == WRITE) ? word_cnt[AW-1:0] : '0;
   assign mem_wdata     = (state == WRITE) ? word_buf : '0;
   assign core_run      = (state == RUN);
   assign busy          = (state == LOAD) || (state == WRITE) || (state == CHECK);
   assign err           = (state == ERR);

   // Fetch path is purely combinational so it adds nothing to the core's
   // single-cycle timing.
   assign mem_raddr   = pc_addr[AW+1:2];
   assign fetch_instr = core_run ? mem_rdata : NOP;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader: a 64-word memory model behind the
// write/read ports, table-driven checks for fetch gating and length
// validation, and hand-written sequences for loads, stalls and reset.
// Define IMEM_LOADER_CHECKSUM_EN for both RTL and bench to cover the
// checksum word.
module tb_imem_loader;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic           clk;
   logic           reset;
   logic [31:0]    pc_addr;
   logic [AW-1:0]  mem_raddr;
   logic [31:0]    mem_rdata;
   logic [31:0]    fetch_instr;
   logic           mem_we;
   logic [AW-1:0]  mem_waddr;
   logic [31:0]    mem_wdata;
   logic           core_run;
   logic           busy;
   logic           err;

   imem_loader_if #(.AW(AW)) ld_if ();

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .ld          (ld_if),
      .pc_addr     (pc_addr),
      .mem_raddr   (mem_raddr),
      .mem_rdata   (mem_rdata),
      .fetch_instr (fetch_instr),
      .mem_we      (mem_we),
      .mem_waddr   (mem_waddr),
      .mem_wdata   (mem_wdata),
      .core_run    (core_run),
      .busy        (busy),
      .err         (err)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory model: seeded with non-NOP markers on the first
   // reset edge, then written whenever the loader pulses mem_we.
   logic [31:0] mem [DEPTH];
   logic        mem_seeded = 1'b0;
   int          we_count   = 0;

   always @(posedge clk) begin
      if (reset && !mem_seeded) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD0000 | i;
         mem_seeded = 1'b1;
      end else if (!reset && mem_we) begin
         mem[mem_waddr] = mem_wdata;
         we_count++;
      end
   end

   assign mem_rdata = mem[mem_raddr];

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   typedef struct {
      logic [31:0]   pc;
      logic [AW-1:0] exp_raddr;
   } fetch_vec_t;

   typedef struct {
      logic [AW:0] len;
      logic        exp_err;
      logic        exp_busy;
      logic        exp_ready;
   } len_vec_t;

   fetch_vec_t fetch_tab [4];
   len_vec_t   len_tab [5];
   logic [7:0] toggle_bytes [4];
   int         we_base;

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end else begin
         passes++;
      end
   endtask

   // One-cycle load request with the given length.
   task automatic applyStimulus(input logic [AW:0] len);
      ld_if.load_start = 1'b1;
      ld_if.load_len   = len;
      tick();
      ld_if.load_start = 1'b0;
   endtask

   // Present a byte and hold it until the loader takes it (bounded wait).
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      ld_if.byte_valid = 1'b1;
      ld_if.byte_data  = b;
      while (!ld_if.byte_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (!ld_if.byte_ready) begin
         checkOutput("byte_ready_wait", 32'(ld_if.byte_ready), 32'd1);
      end else begin
         tick();
      end
      ld_if.byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   initial begin
      fetch_tab[0] = '{32'h0000_0000, 6'd0};
      fetch_tab[1] = '{32'h0000_0004, 6'd1};
      fetch_tab[2] = '{32'h0000_0100, 6'd0};
      fetch_tab[3] = '{32'h0000_00FE, 6'd63};

      len_tab[0] = '{7'd0,   1'b1, 1'b0, 1'b0};
      len_tab[1] = '{7'd65,  1'b1, 1'b0, 1'b0};
      len_tab[2] = '{7'd127, 1'b1, 1'b0, 1'b0};
      len_tab[3] = '{7'd1,   1'b0, 1'b1, 1'b1};
      len_tab[4] = '{7'd64,  1'b0, 1'b1, 1'b1};

      toggle_bytes[0] = 8'hB7;
      toggle_bytes[1] = 8'h50;
      toggle_bytes[2] = 8'h34;
      toggle_bytes[3] = 8'h12;

      reset            = 1'b1;
      pc_addr          = '0;
      ld_if.load_start = 1'b0;
      ld_if.load_len   = '0;
      ld_if.byte_valid = 1'b0;
      ld_if.byte_data  = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state and ten idle cycles: core held, fetches see NOP.
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_waddr", 32'(mem_waddr), 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      for (int c = 0; c < 10; c++) tick();
      checkOutput("idle_core_run", 32'(core_run), 32'd0);
      checkOutput("idle_byte_ready", 32'(ld_if.byte_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         pc_addr = fetch_tab[i].pc;
         #1;
         checkOutput("idle_raddr", 32'(mem_raddr), 32'(fetch_tab[i].exp_raddr));
         checkOutput("idle_fetch_nop", fetch_instr, 32'h00000013);
      end

      // Length validation from a fresh IDLE for each table entry.
      for (int i = 0; i < 5; i++) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
         applyStimulus(len_tab[i].len);
         checkOutput("len_err", 32'(err), 32'(len_tab[i].exp_err));
         checkOutput("len_busy", 32'(busy), 32'(len_tab[i].exp_busy));
         checkOutput("len_ready", 32'(ld_if.byte_ready), 32'(len_tab[i].exp_ready));
         checkOutput("len_no_we", 32'(mem_we), 32'd0);
      end
      checkOutput("len_we_count", 32'(we_count), 32'd0);

      // A bad request while busy is ignored.
      applyStimulus(7'd0);
      checkOutput("busy_ignore_err", 32'(err), 32'd0);
      checkOutput("busy_ignore_busy", 32'(busy), 32'd1);

      // ERR, then a valid request clears it; load two words.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(7'd0);
      checkOutput("err_len0", 32'(err), 32'd1);
      applyStimulus(7'd2);
      checkOutput("err_cleared", 32'(err), 32'd0);
      checkOutput("load_ready", 32'(ld_if.byte_ready), 32'd1);
      send_word(32'h00500513);
      checkOutput("w0_we", 32'(mem_we), 32'd1);
      checkOutput("w0_addr", 32'(mem_waddr), 32'd0);
      checkOutput("w0_data", mem_wdata, 32'h00500513);
      checkOutput("w0_ready_low", 32'(ld_if.byte_ready), 32'd0);
      send_word(32'h00A00593);
      checkOutput("w1_we", 32'(mem_we), 32'd1);
      checkOutput("w1_addr", 32'(mem_waddr), 32'd1);
      checkOutput("w1_data", mem_wdata, 32'h00A00593);
      checkOutput("w1_core_held", 32'(core_run), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(32'h00F00AA6);
`else
      tick();
`endif
      checkOutput("run_core_run", 32'(core_run), 32'd1);
      checkOutput("run_busy", 32'(busy), 32'd0);
      checkOutput("run_we_count", 32'(we_count), 32'd2);
      pc_addr = 32'd4;
      #1;
      checkOutput("run_fetch_pc4", fetch_instr, 32'h00A00593);
      pc_addr = 32'd0;
      #1;
      checkOutput("run_fetch_pc0", fetch_instr, 32'h00500513);

      // Bad request from RUN drops core_run and flags an error.
      applyStimulus(7'd65);
      checkOutput("run_bad_err", 32'(err), 32'd1);
      checkOutput("run_bad_core", 32'(core_run), 32'd0);
      checkOutput("run_bad_nop", fetch_instr, 32'h00000013);

      // One-word load with byte_valid on every other cycle.
      applyStimulus(7'd1);
      for (int i = 0; i < 4; i++) begin
         ld_if.byte_valid = 1'b1;
         ld_if.byte_data  = toggle_bytes[i];
         tick();
         ld_if.byte_valid = 1'b0;
         ld_if.byte_data  = 8'hFF;
         if (i < 3) begin
            checkOutput("tog_ready_on", 32'(ld_if.byte_ready), 32'd1);
            tick();
            checkOutput("tog_ready_gap", 32'(ld_if.byte_ready), 32'd1);
         end
      end
      checkOutput("tog_write_ready", 32'(ld_if.byte_ready), 32'd0);
      checkOutput("tog_we", 32'(mem_we), 32'd1);
      checkOutput("tog_data", mem_wdata, 32'h123450B7);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(32'h123450B7);
`else
      tick();
      checkOutput("tog_after_ready", 32'(ld_if.byte_ready), 32'd0);
`endif
      checkOutput("tog_core_run", 32'(core_run), 32'd1);
      checkOutput("tog_we_count", 32'(we_count), 32'd3);

      // Reset after six bytes of a three-word load.
      applyStimulus(7'd3);
      checkOutput("abort_core_drop", 32'(core_run), 32'd0);
      we_base = we_count;
      send_word(32'hDDCCBBAA);
      send_byte(8'h11);
      send_byte(8'h22);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_core", 32'(core_run), 32'd0);
      checkOutput("abort_ready", 32'(ld_if.byte_ready), 32'd0);
      checkOutput("abort_we_delta", 32'(we_count - we_base), 32'd1);
      checkOutput("abort_mem0", mem[0], 32'hDDCCBBAA);
      checkOutput("abort_mem1", mem[1], 32'h00A00593);
      pc_addr = 32'd4;
      #1;
      checkOutput("abort_fetch_nop", fetch_instr, 32'h00000013);

      // Counters start clean after the reset.
      applyStimulus(7'd1);
      send_word(32'h04030201);
      checkOutput("clean_addr", 32'(mem_waddr), 32'd0);
      checkOutput("clean_data", mem_wdata, 32'h04030201);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(32'h04030201);
`else
      tick();
`endif
      checkOutput("clean_core_run", 32'(core_run), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Wrong checksum ends in ERR with the core held.
      applyStimulus(7'd2);
      we_base = we_count;
      send_word(32'h00500513);
      send_word(32'h00A00593);
      send_word(32'h00000000);
      checkOutput("cks_bad_err", 32'(err), 32'd1);
      checkOutput("cks_bad_core", 32'(core_run), 32'd0);
      checkOutput("cks_bad_busy", 32'(busy), 32'd0);
      checkOutput("cks_we_delta", 32'(we_count - we_base), 32'd2);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
